// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a sequential clear sweep (on rst or clr_req),
// write-through bypass, and an optional pending-write scoreboard enabled by REGFILE_SCOREBOARD_EN.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       writeaddr,
  input  logic [WIDTH-1:0]        writedata,
  input  logic [NREAD*ADDR_W-1:0] readaddr,
  output logic [NREAD*WIDTH-1:0]  readdata,
  input  logic                    clr_req,
  output logic                    busy,
  input  logic                    set_pend,
  input  logic [ADDR_W-1:0]       set_addr,
  output logic [NREAD-1:0]        rd_pend
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [WIDTH-1:0]    mem_wdata;
  logic                idle;
  logic                wr_live;
  logic [ADDR_W-1:0]   raddr [NREAD];
  logic [NREAD-1:0]    bypass_hit;

  assign idle    = (state_q == ST_IDLE);
  assign busy    = (state_q == ST_CLEAR);
  // A write is only visible (stored or bypassed) in IDLE when no clear is starting.
  assign wr_live = idle && we && !clr_req;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = writeaddr;
    mem_wdata = writedata;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = '0;
      ptr_d     = ptr_q + 1'b1;
      if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
    end else if (clr_req) begin
      state_d = ST_CLEAR;
      ptr_d   = '0;
    end else if (we && !(ZERO_REG != 0 && writeaddr == '0)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    readdata   = '0;
    bypass_hit = '0;
    for (int i = 0; i < NREAD; i++) begin
      raddr[i]      = readaddr[i*ADDR_W +: ADDR_W];
      bypass_hit[i] = wr_live && (raddr[i] == writeaddr);
      if (!busy && !(ZERO_REG != 0 && raddr[i] == '0)) begin
        readdata[i*WIDTH +: WIDTH] = bypass_hit[i] ? writedata : mem_q[raddr[i]];
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (idle) begin
      if (clr_req) begin
        pend_d = '0;
      end else begin
        if (we) pend_d[writeaddr] = 1'b0;
        // Applied after the write so a same-address set wins.
        if (set_pend && !(ZERO_REG != 0 && set_addr == '0)) pend_d[set_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  always_comb begin
    rd_pend = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (!busy && !(bypass_hit[i] && !(set_pend && set_addr == raddr[i]))) begin
        rd_pend[i] = pend_q[raddr[i]];
      end
    end
  end
`else
  logic unused_sb;
  assign rd_pend   = '0;
  assign unused_sb = ^{set_pend, set_addr};
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised plus directed bench for regfile_mp with a queue-based scoreboard and abstract model.
module tb_regfile_mp;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int NR = 4;
  localparam int ZR = 1;
  localparam int AW = $clog2(D);

  logic              clk = 1'b0;
  logic              rst, we, clr_req, set_pend, busy;
  logic [AW-1:0]     writeaddr, set_addr;
  logic [W-1:0]      writedata;
  logic [NR*AW-1:0]  readaddr;
  logic [NR*W-1:0]   readdata;
  logic [NR-1:0]     rd_pend;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .ZERO_REG(ZR)) dut (
    .clk(clk), .rst(rst), .we(we), .writeaddr(writeaddr), .writedata(writedata),
    .readaddr(readaddr), .readdata(readdata), .clr_req(clr_req), .busy(busy),
    .set_pend(set_pend), .set_addr(set_addr), .rd_pend(rd_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          busy;
    logic [NR*W-1:0] rd;
    logic [NR-1:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Abstract model: sweep is a countdown; its only visible effect is all-zero storage at the end.
  logic [W-1:0] m_mem  [D];
  bit           m_pend [D];
  int           m_cnt   = 0;
  bit           m_valid = 0;

  task automatic step();
    exp_t e;
    logic [AW-1:0] a;
    bit byp;
    if (m_valid) begin
      e.busy = (m_cnt > 0);
      e.rd   = '0;
      e.pend = '0;
      if (!e.busy) begin
        for (int i = 0; i < NR; i++) begin
          a   = readaddr[i*AW +: AW];
          byp = we && !clr_req && (a == writeaddr);
          if (!(ZR != 0 && a == 0)) e.rd[i*W +: W] = byp ? writedata : m_mem[a];
`ifdef REGFILE_SCOREBOARD_EN
          e.pend[i] = (byp && !(set_pend && set_addr == a)) ? 1'b0 : m_pend[a];
`endif
        end
      end
      exp_q.push_back(e);
    end
    if (rst) begin
      m_valid = 1;
      m_cnt   = D;
      for (int k = 0; k < D; k++) m_pend[k] = 0;
    end else if (m_valid && m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) for (int k = 0; k < D; k++) m_mem[k] = '0;
    end else if (m_valid) begin
      if (clr_req) begin
        m_cnt = D;
        for (int k = 0; k < D; k++) m_pend[k] = 0;
      end else begin
        if (we && !(ZR != 0 && writeaddr == 0)) m_mem[writeaddr] = writedata;
        if (we) m_pend[writeaddr] = 0;
        if (set_pend && !(ZR != 0 && set_addr == 0)) m_pend[set_addr] = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int p, input int a);
    readaddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic rnd_reads();
    for (int p = 0; p < NR; p++)
      set_ra(p, ($urandom % 4 == 0) ? int'(writeaddr) : int'($urandom % D));
  endtask

  task automatic idle_in();
    rst = 0; we = 0; clr_req = 0; set_pend = 0;
  endtask

  // Monitor: outputs are combinational, so one expected entry is presented per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (busy !== e.busy) begin
          n_err++;
          $display("FAIL busy t=%0t got=%b want=%b", $time, busy, e.busy);
        end
        n_checks++;
        if (readdata !== e.rd) begin
          n_err++;
          $display("FAIL readdata t=%0t got=%h want=%h", $time, readdata, e.rd);
        end
        n_checks++;
        if (rd_pend !== e.pend) begin
          n_err++;
          $display("FAIL rd_pend t=%0t got=%b want=%b", $time, rd_pend, e.pend);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    rst = 1; writeaddr = '0; writedata = '0; set_addr = '0; readaddr = '0;
    step(); step();

    // Reset sweep; a write and a set during busy must be lost.
    rst = 0;
    for (int c = 0; c < D + 2; c++) begin
      rnd_reads();
      we = (c == 3); writeaddr = 5; writedata = 32'hDEAD;
      set_pend = (c == 3); set_addr = 5;
      if (c >= D) set_ra(0, 5);
      step();
    end
    idle_in();

    // Write with same-cycle bypass, then from storage; entry 0 ignores writes.
    we = 1; writeaddr = 6; writedata = 32'h1234_5678; set_ra(0, 6);
    step();
    we = 0; step();
    we = 1; writeaddr = 0; writedata = 32'hFFFF_FFFF; set_ra(0, 0); set_ra(1, 0);
    step();
    we = 0; step();

    // Multi-port reads of distinct entries.
    for (int k = 1; k <= 4; k++) begin
      we = 1; writeaddr = AW'(k); writedata = 32'h11 * k;
      step();
    end
    we = 0;
    set_ra(0, 4); set_ra(1, 3); set_ra(2, 2); set_ra(3, 1);
    step();

    // clr_req beats a same-cycle write.
    we = 1; writeaddr = 9; writedata = 32'hAA; step();
    clr_req = 1; writeaddr = 10; writedata = 32'hBB; step();
    idle_in();
    set_ra(0, 9); set_ra(1, 10);
    for (int c = 0; c < D + 2; c++) step();

    // rst in the middle of a sweep restarts it.
    clr_req = 1; step();
    clr_req = 0;
    for (int c = 0; c < 10; c++) begin rnd_reads(); step(); end
    rst = 1; step();
    rst = 0;
    for (int c = 0; c < D + 2; c++) begin rnd_reads(); step(); end

    // Scoreboard: set, clear by write (bypassed), same-cycle set+write.
    set_ra(0, 7); set_ra(1, 7);
    set_pend = 1; set_addr = 7; step();
    set_pend = 0; step();
    we = 1; writeaddr = 7; writedata = 32'h1; step();
    we = 0; step();
    set_pend = 1; we = 1; step();
    idle_in(); step();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom % 300 == 0);
      clr_req   = ($urandom % 60 == 0);
      we        = $urandom % 2;
      writeaddr = AW'($urandom);
      writedata = $urandom;
      set_pend  = ($urandom % 3 == 0);
      set_addr  = ($urandom % 2) ? writeaddr : AW'($urandom);
      rnd_reads();
      step();
    end
    idle_in();

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the 32x32 two-read/one-write register file.
- Generalised in data width, depth and read-port count.
- Keeps the optional hardwired-zero entry 0 and write-through bypass.
- Adds a sequential clear engine run on reset or on request, a busy/stall output, and an optional per-entry pending-write scoreboard for the pipeline hazard unit.
- Sits in the core datapath between decode (reads) and writeback (write).

Parameters:
WIDTH, 32, data width of each entry
DEPTH, 32, number of entries; power of two, >= 2
NREAD, 2, number of combinational read ports, >= 1
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is ordinary storage
ADDR_W, $clog2(DEPTH), derived address width; not overridden

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
we  in  1  write enable
writeaddr  in  ADDR_W  write address
writedata  in  WIDTH  write data
readaddr  in  NREAD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
readdata  out  NREAD*WIDTH  packed read data; port i uses bits [i*WIDTH +: WIDTH]
clr_req  in  1  one-cycle request to zero all entries
busy  out  1  clear sweep in progress; upstream must stall
set_pend  in  1  mark set_addr as awaiting a writeback (scoreboard)
set_addr  in  ADDR_W  entry to mark pending
rd_pend  out  NREAD  per-read-port pending flag

Behaviour:
- States are CLEAR and IDLE. A posedge with rst=1 forces state=CLEAR, ptr=0 and clears all pend bits. rst overrides everything, including mid-sweep.
- CLEAR:
  - Each cycle writes 0 to mem[ptr], then ptr++.
  - On the edge where ptr==DEPTH-1, the last entry is zeroed and state goes to IDLE.
  - busy=1 in CLEAR, for exactly DEPTH cycles after rst deasserts.
  - All readdata=0 and all rd_pend=0 while busy.
  - we, set_pend and clr_req are ignored while busy; writes are dropped, not queued.
- IDLE:
  - busy=0.
  - clr_req=1 moves to CLEAR with ptr=0 and clears all pend bits.
  - clr_req has priority over a same-cycle we: that write is dropped.
- Write: in IDLE with we=1 and no clr_req, mem[writeaddr] <= writedata on posedge. When ZERO_REG=1, writes to address 0 are discarded.
- Read (combinational, per port i, in priority order):
  - ZERO_REG=1 and addr==0 -> 0.
  - Else if we, IDLE, no clr_req and addr==writeaddr -> writedata (bypass).
  - Else mem[addr].
  - Multiple ports may read the same address.
- Reset values: busy=1 and readdata=0 from the first rst edge; rd_pend=0. The mem array is zeroed only by the sweep.
- Wrap/width: ptr is ADDR_W bits. It does not wrap back into CLEAR; the state change ends the sweep.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN
- With the macro defined:
  - A DEPTH-bit pend register is kept.
  - In IDLE, set_pend sets pend[set_addr]; a write sets pend[writeaddr] to 0.
  - If set and write hit the same address in one cycle, set wins.
  - pend[0] is never set when ZERO_REG=1.
  - rd_pend[i] = pend[readaddr_i], except it reads 0 when a same-cycle bypassing write matches readaddr_i and set_pend does not also target it.
  - Cleared on rst and clr_req.
- Without the macro: no pend storage; rd_pend is tied to 0; set_pend and set_addr are unused.

Test Plan:
- Reset sweep, DEPTH=32: rst high 2 cycles, then low -> busy=1 for exactly 32 cycles then 0; read of every address returns 0; a we to addr 5 with 0xDEAD during busy is lost (reads 0 after).
- Write/read/bypass: IDLE, we=1, writeaddr=6, writedata=0x12345678, readaddr0=6 same cycle -> readdata0=0x12345678 that cycle and from mem the next cycle; write to addr 0 with ZERO_REG=1 -> reads 0.
- Multi-port, NREAD=4, WIDTH=16: write addrs 1..4 with 0x0011,0x0022,0x0033,0x0044; set readaddr ports to 4,3,2,1 -> readdata = {0x0011,0x0022,0x0033,0x0044} (port3..port0).
- clr_req collision: load addr 9=0xAA, then clr_req=1 with we=1 to addr 10=0xBB -> busy next cycle for DEPTH cycles; afterwards addr 9 and 10 both read 0.
- Reset mid-sweep: assert rst at sweep cycle 10 -> ptr restarts at 0; busy stays 1 for a full DEPTH cycles after rst deasserts.
- Scoreboard (REGFILE_SCOREBOARD_EN): set_pend addr 7 -> rd_pend for readaddr 7 is 1 next cycle; write addr 7 -> rd_pend is 0 in the write cycle via bypass and after; same-cycle set+write on addr 7 -> stays pending.
